// File: rtl/piso_pkg.sv
// Shared types and build-time constants for the parallel-in serial-out serializer.
// Optional parity bit is enabled by defining PISO_PARITY_EN.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

`ifdef PISO_PARITY_EN
    localparam int PAR_LEN = 1;
`else
    localparam int PAR_LEN = 0;
`endif

endpackage

// File: rtl/piso_bit_cnt.sv
// Frame bit counter: cleared on reset or load, steps on each accepted serial bit, flags the last bit.
// Saturates at FRAME_LEN so it never wraps between frames.
module piso_bit_cnt #(
    parameter int FRAME_LEN = 4,
    parameter int CW        = $clog2(FRAME_LEN + 1)
) (
    input  logic clk,
    input  logic clear,
    input  logic inc,
    output logic last
);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (clear) begin
            cnt <= '0;
        end else if (inc && (cnt != CW'(FRAME_LEN))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign last = (cnt == CW'(FRAME_LEN - 1));

endmodule

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register with valid/ready load and per-bit serial handshake.
// Build option PISO_PARITY_EN appends an even-parity bit after the data bits.
module piso_shift_reg
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter int LSB_FIRST = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] p_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             s_out,
    output logic             s_valid,
    input  logic             s_ready,
    output logic             busy,
    output logic             done
);

    localparam int FRAME_LEN = WIDTH + PAR_LEN;

    state_t               state;
    logic [FRAME_LEN-1:0] sr;
    logic [FRAME_LEN-1:0] frame;
    logic [FRAME_LEN-1:0] shifted;
    logic                 last;
    logic                 accept;
    logic                 adv;

    function automatic logic head(input logic [FRAME_LEN-1:0] v);
        return (LSB_FIRST != 0) ? v[0] : v[FRAME_LEN-1];
    endfunction

    // Parity sits at whichever end of the register leaves last.
    always_comb begin
        frame = '0;
`ifdef PISO_PARITY_EN
        if (LSB_FIRST != 0) begin
            frame = {^p_in, p_in};
        end else begin
            frame = {p_in, ^p_in};
        end
`else
        frame = p_in;
`endif
    end

    assign shifted    = (LSB_FIRST != 0) ? (sr >> 1) : (sr << 1);
    assign adv        = (state == SHIFT) && s_ready;
    assign load_ready = !clr && ((state == IDLE) || ((state == SHIFT) && last && s_ready));
    assign done       = !clr && (state == SHIFT) && last && s_ready;
    assign accept     = load_valid && load_ready;

    piso_bit_cnt #(
        .FRAME_LEN (FRAME_LEN)
    ) u_bit_cnt (
        .clk   (clk),
        .clear (clr || accept),
        .inc   (adv),
        .last  (last)
    );

    always_ff @(posedge clk) begin
        if (clr) begin
            state   <= IDLE;
            sr      <= '0;
            s_out   <= 1'b0;
            s_valid <= 1'b0;
            busy    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state   <= SHIFT;
                        sr      <= frame;
                        s_out   <= head(frame);
                        s_valid <= 1'b1;
                        busy    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (s_ready) begin
                        if (accept) begin
                            // Reload on the last bit for a gapless next frame.
                            sr    <= frame;
                            s_out <= head(frame);
                        end else if (last) begin
                            state   <= IDLE;
                            sr      <= shifted;
                            s_out   <= 1'b0;
                            s_valid <= 1'b0;
                            busy    <= 1'b0;
                        end else begin
                            sr    <= shifted;
                            s_out <= head(shifted);
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    s_valid <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_piso_shift_reg.sv
// Bench for piso_shift_reg: MSB-first and LSB-first instances driven in lockstep against a queue-based frame model.
module tb_piso_shift_reg;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk;
    logic         clr;
    logic [W-1:0] p_in;
    logic         load_valid;
    logic         s_ready;
    logic         load_ready0, s_out0, s_valid0, busy0, done0;
    logic         load_ready1, s_out1, s_valid1, busy1, done1;

    int n_cmp  = 0;
    int n_fail = 0;

    // Remaining bits of the frame in flight, in transmit order, per instance.
    bit q0[$];
    bit q1[$];

    piso_shift_reg #(.WIDTH(W), .LSB_FIRST(0)) dut0 (
        .clk(clk), .clr(clr), .p_in(p_in), .load_valid(load_valid), .load_ready(load_ready0),
        .s_out(s_out0), .s_valid(s_valid0), .s_ready(s_ready), .busy(busy0), .done(done0)
    );

    piso_shift_reg #(.WIDTH(W), .LSB_FIRST(1)) dut1 (
        .clk(clk), .clr(clr), .p_in(p_in), .load_valid(load_valid), .load_ready(load_ready1),
        .s_out(s_out1), .s_valid(s_valid1), .s_ready(s_ready), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {s_valid0, s_out0, busy0, done0, load_ready0,
                s_valid1, s_out1, busy1, done1, load_ready1};
    endfunction

    function automatic logic [9:0] expected();
        int   n;
        logic v, b0, b1, dn, lr;
        n  = q0.size();
        v  = (n > 0);
        b0 = v ? q0[0] : 1'b0;
        b1 = v ? q1[0] : 1'b0;
        dn = !clr && (n == 1) && s_ready;
        lr = !clr && ((n == 0) || ((n == 1) && s_ready));
        return {v, b0, v, dn, lr, v, b1, v, dn, lr};
    endfunction

    // Advance one clock and update the frame model from the inputs seen at that edge.
    task automatic step();
        int   n;
        logic lr;
        n  = q0.size();
        lr = !clr && ((n == 0) || ((n == 1) && s_ready));
        @(posedge clk);
        if (clr) begin
            q0.delete();
            q1.delete();
        end else begin
            if (n > 0 && s_ready) begin
                void'(q0.pop_front());
                void'(q1.pop_front());
            end
            if (load_valid && lr) begin
                for (int i = 0; i < W; i++) begin
                    q0.push_back(p_in[W-1-i]);
                    q1.push_back(p_in[i]);
                end
`ifdef PISO_PARITY_EN
                q0.push_back(^p_in);
                q1.push_back(^p_in);
`endif
            end
        end
        #1;
    endtask

    task automatic test_reset();
        clr = 1'b1; load_valid = 1'b1; p_in = W'($urandom); s_ready = 1'b1;
        step();
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL reset cyc %0d: got %b want %b", c, observed(), expected());
            end
            n_cmp++;
            if ({s_valid0, busy0, load_ready0, done0} !== 4'b0000) begin
                n_fail++;
                $display("FAIL reset_held: got %b want 0000", {s_valid0, busy0, load_ready0, done0});
            end
            step();
        end
        clr = 1'b0; load_valid = 1'b0;
        @(negedge clk);
        n_cmp++;
        if ({s_valid0, s_out0, busy0, done0, load_ready0} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_after: got %b want 00001", {s_valid0, s_out0, busy0, done0, load_ready0});
        end
        step();
    endtask

    task automatic test_basic();
        logic [W-1:0] seq0, seq1;
        int done_at;
        seq0 = '0; seq1 = '0; done_at = -1;
        clr = 1'b0; s_ready = 1'b1; p_in = 4'b1010; load_valid = 1'b1;
        for (int c = 0; c <= FL + 1; c++) begin
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL basic cyc %0d: got %b want %b", c, observed(), expected());
            end
            if (c >= 1 && c <= W) begin
                seq0 = {seq0[W-2:0], s_out0};
                seq1 = {seq1[W-2:0], s_out1};
            end
            if (done0) done_at = c;
            step();
            load_valid = 1'b0;
        end
        n_cmp++;
        if (seq0 !== 4'b1010) begin
            n_fail++;
            $display("FAIL basic_msb_bits: got %b want 1010", seq0);
        end
        n_cmp++;
        if (seq1 !== 4'b0101) begin
            n_fail++;
            $display("FAIL basic_lsb_bits: got %b want 0101", seq1);
        end
        n_cmp++;
        if (done_at != FL) begin
            n_fail++;
            $display("FAIL basic_done_cycle: got %0d want %0d", done_at, FL);
        end
    endtask

    task automatic test_lsb();
        logic [W-1:0] seq0, seq1;
        seq0 = '0; seq1 = '0;
        s_ready = 1'b1; p_in = 4'b0001; load_valid = 1'b1;
        for (int c = 0; c <= FL + 1; c++) begin
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL lsb cyc %0d: got %b want %b", c, observed(), expected());
            end
            if (c >= 1 && c <= W) begin
                seq0 = {seq0[W-2:0], s_out0};
                seq1 = {seq1[W-2:0], s_out1};
            end
            step();
            load_valid = 1'b0;
        end
        n_cmp++;
        if (seq1 !== 4'b1000) begin
            n_fail++;
            $display("FAIL lsb_first_bits: got %b want 1000", seq1);
        end
        n_cmp++;
        if (seq0 !== 4'b0001) begin
            n_fail++;
            $display("FAIL lsb_msb_inst_bits: got %b want 0001", seq0);
        end
    endtask

    task automatic test_back_to_back();
        int acc, nv, nd;
        acc = 0; nv = 0; nd = 0;
        s_ready = 1'b1; p_in = 4'b1100; load_valid = 1'b1;
        for (int c = 0; c <= 2 * FL + 1; c++) begin
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL b2b cyc %0d: got %b want %b", c, observed(), expected());
            end
            if (c >= 1 && c <= 2 * FL && s_valid0) nv++;
            if (done0) nd++;
            if (load_valid && load_ready0) acc++;
            step();
            if (acc == 1) p_in = 4'b0011;
            if (acc >= 2) load_valid = 1'b0;
        end
        n_cmp++;
        if (nv != 2 * FL) begin
            n_fail++;
            $display("FAIL b2b_contiguous: got %0d valid cycles want %0d", nv, 2 * FL);
        end
        n_cmp++;
        if (nd != 2) begin
            n_fail++;
            $display("FAIL b2b_done_count: got %0d want 2", nd);
        end
    endtask

    task automatic test_stall();
        int nd, done_at;
        logic [2:0] held;
        nd = 0; done_at = -1; held = 3'b111;
        p_in = 4'b1010; load_valid = 1'b1;
        for (int c = 0; c <= FL + 4; c++) begin
            s_ready = !(c >= 2 && c <= 4);
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL stall cyc %0d: got %b want %b", c, observed(), expected());
            end
            if (c >= 2 && c <= 4) held = {held[1:0], s_out0};
            if (done0) begin
                nd++;
                done_at = c;
            end
            step();
            load_valid = 1'b0;
        end
        s_ready = 1'b1;
        n_cmp++;
        if (held !== 3'b000) begin
            n_fail++;
            $display("FAIL stall_hold: got %b want 000", held);
        end
        n_cmp++;
        if (nd != 1 || done_at != FL + 3) begin
            n_fail++;
            $display("FAIL stall_done: got %0d pulses at %0d want 1 at %0d", nd, done_at, FL + 3);
        end
    endtask

    task automatic test_clr_mid();
        int nd;
        logic [2:0] idle_vec;
        nd = 0; idle_vec = 3'b111;
        p_in = W'($urandom); load_valid = 1'b1; s_ready = 1'b1;
        for (int c = 0; c <= 5; c++) begin
            clr = (c == 3);
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL clr_mid cyc %0d: got %b want %b", c, observed(), expected());
            end
            if (done0 || done1) nd++;
            if (c == 4) idle_vec = {s_valid0, busy0, load_ready0};
            step();
            load_valid = 1'b0;
        end
        clr = 1'b0;
        n_cmp++;
        if (nd != 0 || idle_vec !== 3'b001) begin
            n_fail++;
            $display("FAIL clr_mid_abandon: got done=%0d idle=%b want done=0 idle=001", nd, idle_vec);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            clr        = ($urandom_range(0, 49) == 0);
            load_valid = ($urandom_range(0, 2) != 0);
            s_ready    = ($urandom_range(0, 3) != 0);
            p_in       = W'($urandom);
            @(negedge clk);
            n_cmp++;
            if (observed() !== expected()) begin
                n_fail++;
                $display("FAIL random cyc %0d: got %b want %b", c, observed(), expected());
            end
            step();
        end
        clr = 1'b0; load_valid = 1'b0; s_ready = 1'b1;
    endtask

    initial begin
        clr = 1'b1; p_in = '0; load_valid = 1'b0; s_ready = 1'b0;
        test_reset();
        test_basic();
        test_lsb();
        test_back_to_back();
        test_stall();
        test_clr_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
